// File: rtl/sw_bcast_rx_if.sv
// Bundle of broadcast/local store inputs, memory write port, forwarding and status
// signals for the child-core store broadcast receiver.
interface sw_bcast_rx_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              bc_valid;
  logic [ADDR_W-1:0] bc_addr;
  logic [DATA_W-1:0] bc_data;
  logic              local_we;
  logic [ADDR_W-1:0] local_addr;
  logic [DATA_W-1:0] local_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [ADDR_W-1:0] ld_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  count;
  logic              drain_empty;
  logic              overflow;

  modport master (
    output bc_valid, bc_addr, bc_data, local_we, local_addr, local_data, ld_addr,
    input  mem_we, mem_addr, mem_din, fwd_hit, fwd_data, count, drain_empty, overflow
  );

  modport slave (
    input  bc_valid, bc_addr, bc_data, local_we, local_addr, local_data, ld_addr,
    output mem_we, mem_addr, mem_din, fwd_hit, fwd_data, count, drain_empty, overflow
  );
endinterface

// File: rtl/sw_bcast_rx.sv
// Child-core store broadcast receiver: arbitrates local stores vs. broadcasts onto the
// data memory write port, buffers losing broadcasts in a FIFO and forwards pending data.
module sw_bcast_rx #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input logic         clk,
  input logic         reset,
  sw_bcast_rx_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic              jw_valid_q;
  logic [ADDR_W-1:0] jw_addr_q;
  logic [DATA_W-1:0] jw_data_q;

  logic              empty, full, pop, bypass, push_req, push, drop;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              fifo_hit;
  logic [DATA_W-1:0] fifo_fwd;
  logic [PTR_W-1:0]  idx;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    pop      = !reset && !bus.local_we && !empty;
    bypass   = !reset && !bus.local_we && empty && bus.bc_valid;
    push_req = !reset && bus.bc_valid && !bypass;
    // A same-cycle pop frees the slot the push needs.
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;

    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (!reset) begin
      if (bus.local_we) begin
        mem_we   = 1'b1;
        mem_addr = bus.local_addr;
        mem_din  = bus.local_data;
      end else if (!empty) begin
        mem_we   = 1'b1;
        mem_addr = fifo_addr_q[rd_ptr_q];
        mem_din  = fifo_data_q[rd_ptr_q];
      end else if (bus.bc_valid) begin
        mem_we   = 1'b1;
        mem_addr = bus.bc_addr;
        mem_din  = bus.bc_data;
      end
    end
  end

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fifo_hit = 1'b0;
    fifo_fwd = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q && fifo_addr_q[idx] == bus.ld_addr) begin
        fifo_hit = 1'b1;
        fifo_fwd = fifo_data_q[idx];
      end
    end

    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (!reset) begin
      if (fifo_hit) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_fwd;
      end else if (mem_we && mem_addr == bus.ld_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_din;
      end else if (jw_valid_q && jw_addr_q == bus.ld_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = jw_data_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      jw_valid_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= bus.bc_addr;
        fifo_data_q[wr_ptr_q] <= bus.bc_data;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
      jw_valid_q <= mem_we;
      if (mem_we) begin
        jw_addr_q <= mem_addr;
        jw_data_q <= mem_din;
      end
    end
  end

  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_din     = mem_din;
  assign bus.fwd_hit     = fwd_hit;
  assign bus.fwd_data    = fwd_data;
  assign bus.count       = count_q;
  assign bus.drain_empty = empty && !mem_we;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_sw_bcast_rx.sv
// Randomized and directed bench for sw_bcast_rx against a queue-based reference model.
module tb_sw_bcast_rx;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sw_bcast_rx_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sw_bcast_rx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state
  ent_t              q[$];
  logic              m_ovf  = 1'b0;
  logic              m_jw_v = 1'b0;
  logic [ADDR_W-1:0] m_jw_a = '0;
  logic [DATA_W-1:0] m_jw_d = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int max_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock cycle: drive, check combinational outputs against the model, advance model.
  task automatic cycle(input logic rst, input logic bcv, input logic [ADDR_W-1:0] ba,
                       input logic [DATA_W-1:0] bd, input logic lw,
                       input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ldat,
                       input logic [ADDR_W-1:0] lda);
    int                src;
    logic              e_we, e_hit;
    logic [ADDR_W-1:0] e_a;
    logic [DATA_W-1:0] e_d, e_fd;
    @(negedge clk);
    reset          = rst;
    bus.bc_valid   = bcv;
    bus.bc_addr    = ba;
    bus.bc_data    = bd;
    bus.local_we   = lw;
    bus.local_addr = la;
    bus.local_data = ldat;
    bus.ld_addr    = lda;
    #1;
    src = 0; e_we = 1'b0; e_a = '0; e_d = '0;
    if (!rst) begin
      if (lw) begin src = 1; e_we = 1'b1; e_a = la; e_d = ldat; end
      else if (q.size() > 0) begin src = 2; e_we = 1'b1; e_a = q[0].a; e_d = q[0].d; end
      else if (bcv) begin src = 3; e_we = 1'b1; e_a = ba; e_d = bd; end
    end
    e_hit = 1'b0; e_fd = '0;
    if (!rst) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a == lda) begin e_hit = 1'b1; e_fd = q[i].d; break; end
      end
      if (!e_hit && e_we && e_a == lda) begin e_hit = 1'b1; e_fd = e_d; end
      else if (!e_hit && m_jw_v && m_jw_a == lda) begin e_hit = 1'b1; e_fd = m_jw_d; end
    end
    check("mem_we", 64'(bus.mem_we), 64'(e_we));
    if (e_we) begin
      check("mem_addr", 64'(bus.mem_addr), 64'(e_a));
      check("mem_din", 64'(bus.mem_din), 64'(e_d));
    end
    check("fwd_hit", 64'(bus.fwd_hit), 64'(e_hit));
    check("fwd_data", 64'(bus.fwd_data), 64'(e_fd));
    check("count", 64'(bus.count), 64'(q.size()));
    check("drain_empty", 64'(bus.drain_empty), 64'(q.size() == 0 && !e_we));
    check("overflow", 64'(bus.overflow), 64'(m_ovf));
    if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf  = 1'b0;
      m_jw_v = 1'b0;
    end else begin
      if (src == 2) void'(q.pop_front());
      if (bcv && src != 3) begin
        if (q.size() < DEPTH) q.push_back('{a: ba, d: bd});
        else m_ovf = 1'b1;
      end
      m_jw_v = e_we;
      if (e_we) begin m_jw_a = e_a; m_jw_d = e_d; end
    end
  endtask

  task automatic idle(input logic [ADDR_W-1:0] lda);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, lda);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    bus.bc_valid = 1'b0; bus.bc_addr = '0; bus.bc_data = '0;
    bus.local_we = 1'b0; bus.local_addr = '0; bus.local_data = '0; bus.ld_addr = '0;
    do_reset();
    do_reset();

    // Bypass on idle FIFO, then forward from just-written register
    cycle(1'b0, 1'b1, 15'h10, 32'hAAAA, 1'b0, '0, '0, 15'h10);
    idle(15'h10);

    // Local stores hold the port for 5 cycles; 5th broadcast is dropped
    for (int i = 1; i <= 5; i++)
      cycle(1'b0, 1'b1, ADDR_W'(i), DATA_W'(i * 32'h11), 1'b1, ADDR_W'(15'h100 + i),
            DATA_W'(i), ADDR_W'(i));
    for (int i = 0; i < 6; i++) idle(15'h3);
    check("overflow_sticky", 64'(bus.overflow), 64'd1);
    check("drained", 64'(bus.drain_empty), 64'd1);

    // Full FIFO plus one pop accepts a new broadcast
    do_reset();
    for (int i = 1; i <= 4; i++)
      cycle(1'b0, 1'b1, ADDR_W'(i), DATA_W'(i), 1'b1, 15'h200, 32'h5, 15'h0);
    cycle(1'b0, 1'b1, 15'h9, 32'h99, 1'b0, '0, '0, 15'h9);
    check("full_pop_count", 64'(bus.count), 64'd4);
    check("full_pop_ovf", 64'(bus.overflow), 64'd0);
    for (int i = 0; i < 5; i++) idle(15'h9);

    // Youngest of two same-address entries is forwarded
    do_reset();
    cycle(1'b0, 1'b1, 15'h7, 32'h1, 1'b1, 15'h300, 32'h0, 15'h7);
    cycle(1'b0, 1'b1, 15'h7, 32'h2, 1'b1, 15'h301, 32'h0, 15'h7);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 15'h302, 32'h0, 15'h7);
    check("fwd_youngest", 64'(bus.fwd_data), 64'h2);
    for (int i = 0; i < 3; i++) idle(15'h7);

    // Reset with three entries pending and a broadcast arriving
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, ADDR_W'(15'h40 + i), DATA_W'(i), 1'b1, 15'h50, 32'h0, 15'h0);
    cycle(1'b1, 1'b1, 15'h44, 32'h44, 1'b1, 15'h51, 32'h1, 15'h44);
    idle(15'h44);

    // Alternating local and broadcast traffic
    max_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cycle(1'b0, 1'b0, '0, '0, 1'b1, ADDR_W'(15'h60 + i), DATA_W'(i), 15'h0);
      else cycle(1'b0, 1'b1, ADDR_W'(15'h70 + i), DATA_W'(i), 1'b0, '0, '0, 15'h0);
    end
    check("alt_max_count_le2", 64'(max_cnt <= 2), 64'd1);
    check("alt_no_drop", 64'(bus.overflow), 64'd0);

    // Random traffic with a small address space to exercise forwarding
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7),
            ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
            ($urandom_range(0, 9) < 4), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
            ADDR_W'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 6; i++) idle(15'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
